// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and BCD helpers for the score keeper
// Purpose: game_state enum, packed 2-digit BCD type, binary->BCD and BCD increment.
// Ports: none (package).
package scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    WON_A = 2'd2,
    WON_B = 2'd3
  } game_state_t;

  typedef logic [7:0] bcd2_t;

  // Binary 0..99 to packed BCD; used to build the win threshold constant.
  function automatic bcd2_t bin2bcd(input int unsigned v);
    bcd2_t r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // +1 in packed BCD; ones digit wraps 9->0 with a carry into tens.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer, debouncer and rising-edge pulse for one button
// Purpose: condition a raw bouncing button into a single 1-cycle press pulse.
// Ports: clk, rst_n (async active-low), i_run (internal reset released),
//        i_btn (raw button), o_pulse (1-cycle pulse per debounced press).
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  r_sync;
  logic        r_level;
  logic        r_level_d;
  logic        r_pulse;
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else if (!i_run) begin
      // Held cleared until the internal reset release has propagated, so a
      // button held through reset is seen as a fresh press.
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // r_cnt counts consecutive samples that disagree with the accepted
      // level; any agreeing sample restarts the count.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-team BCD scoreboard with debounced buttons and win detection
// Purpose: game FSM and BCD score registers driven by three debounced buttons.
// Ports: clk, rst_n (async active-low), btn_a/btn_b/btn_clr (raw buttons),
//        score_a/score_b (packed BCD), game_state (0 IDLE,1 PLAY,2 WON_A,3 WON_B),
//        score_evt (1-cycle pulse when a score register changed).
module score_keeper
  import scoreboard_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WIN_SCORE       = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_clr,
  output logic [7:0] score_a,
  output logic [7:0] score_b,
  output logic [1:0] game_state,
  output logic       score_evt
);

  localparam bcd2_t WIN_BCD = bin2bcd(WIN_SCORE);

  logic [1:0]  r_rst_sync;
  bcd2_t       r_score_a;
  bcd2_t       r_score_b;
  game_state_t r_state;
  logic        r_evt;

  logic  w_run;
  logic  w_pulse_a;
  logic  w_pulse_b;
  logic  w_pulse_clr;
  bcd2_t w_next_a;
  bcd2_t w_next_b;

  // Asynchronous assert, synchronous release of the internal run enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .i_run(w_run), .i_btn(btn_a), .o_pulse(w_pulse_a)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .i_run(w_run), .i_btn(btn_b), .o_pulse(w_pulse_b)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk(clk), .rst_n(rst_n), .i_run(w_run), .i_btn(btn_clr), .o_pulse(w_pulse_clr)
  );

  assign w_next_a = w_pulse_a ? bcd_inc(r_score_a) : r_score_a;
  assign w_next_b = w_pulse_b ? bcd_inc(r_score_b) : r_score_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score_a <= '0;
      r_score_b <= '0;
      r_state   <= IDLE;
      r_evt     <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (w_pulse_clr) begin
        r_score_a <= '0;
        r_score_b <= '0;
        r_state   <= IDLE;
        r_evt     <= (r_score_a != '0) || (r_score_b != '0);
      end else begin
        case (r_state)
          IDLE, PLAY: begin
            if (w_pulse_a || w_pulse_b) begin
              r_score_a <= w_next_a;
              r_score_b <= w_next_b;
              r_evt     <= 1'b1;
              // A is checked first so a simultaneous win goes to team A.
              if (w_next_a == WIN_BCD) begin
                r_state <= WON_A;
              end else if (w_next_b == WIN_BCD) begin
                r_state <= WON_B;
              end else begin
                r_state <= PLAY;
              end
            end
          end
          default: begin
            // Won states: scores frozen until a clear.
          end
        endcase
      end
    end
  end

  assign score_a    = r_score_a;
  assign score_b    = r_score_b;
  assign game_state = r_state;
  assign score_evt  = r_evt;

endmodule
